pkt_frame_tx: RTL
=================

Name: pkt_frame_tx

Overview:
- Transmit end of the head/data/tail packet framing protocol: generates `valid`/`head`/`tail`/`data` beats for the framing receiver FSM.
- On a start request it emits:
  - one header beat, carrying the payload length;
  - `len` payload beats, pulled from a show-ahead source;
  - one tail beat, carrying the XOR checksum of the payload.
- Honours receiver backpressure via `ready`.
- Sits between a payload buffer and the link carrying framed packets.

Parameters:
- DATA_W, 8, width of `data`/`payload` words.
- LEN_W, 4, width of `len`. Must satisfy LEN_W <= DATA_W.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send one packet; sampled only when accepted (see Behaviour).
- len  input  LEN_W  number of payload beats (0 to 2^LEN_W-1); sampled with `start`.
- payload  input  DATA_W  current payload word; must be valid whenever `payload_req`=1.
- payload_req  output  1  combinational; pops one payload word this cycle.
- ready  input  1  receiver can accept a beat this cycle.
- valid  output  1  registered; beat present on `data`.
- head  output  1  registered; current beat is the header.
- tail  output  1  registered; current beat is the tail.
- data  output  DATA_W  registered beat data.
- state  output  2  current FSM state, for coverage.
- busy  output  1  state != IDLE.
- done  output  1  registered one-cycle pulse the cycle after a tail beat is accepted.

Behaviour:
- States: IDLE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.
- Reset (asynchronous, any time including mid-packet):
  - state=IDLE; valid, head, tail, data, done, checksum, beat counter all 0.
  - payload_req=0.
  - A partial packet is abandoned; no tail is sent.
- Accept: `acc` = valid & ready. When `acc`=0, all registered outputs hold their values; `ready` is ignored when `valid`=0.
- IDLE:
  - If start=1: next state is HEAD; latch len into the counter; clear checksum.
  - Load valid=1, head=1, tail=0, data=len zero-extended to DATA_W.
  - Otherwise remain in IDLE with valid=0.
- HEAD, on acc:
  - If len=0: go to TAIL and load a tail beat with data=0.
  - Otherwise: go to DATA, assert payload_req, load data=payload, head=0, and decrement the counter.
- DATA, on acc:
  - If the counter is nonzero: stay in DATA, assert payload_req, load the next payload, decrement the counter.
  - If the counter is zero: go to TAIL and load tail=1, data=checksum.
- Checksum: XOR of every payload word loaded into `data` for the current packet. It is updated on the same edge that loads the word.
- TAIL, on acc:
  - done pulses next cycle.
  - If start=1 in the same cycle: go to HEAD back-to-back with no idle gap; latch the new len, clear checksum, load the header beat.
  - Otherwise: go to IDLE with valid=0, head=0, tail=0.
- `start` is ignored in HEAD and DATA, and in TAIL without acc.
- payload_req = acc & (next state == DATA). It is never asserted while the beat is stalled.
- Latency:
  - Header is visible on `valid` one cycle after start is sampled.
  - Full packet with ready held at 1 takes len+2 beats on consecutive cycles.
- Flag invariants:
  - head and tail are never both 1.
  - head, tail and data beats occur only with valid=1.
- Reachable transitions are exactly:
  - IDLE->IDLE, IDLE->HEAD
  - HEAD->DATA, HEAD->TAIL
  - DATA->DATA, DATA->TAIL
  - TAIL->HEAD, TAIL->IDLE
- Self-loops HEAD->HEAD, DATA->DATA and TAIL->TAIL also occur as stalls (acc=0).

Test Plan:
1. Reset held 3 cycles, then start=1, len=3, payloads 8'h11, 8'h22, 8'h44, ready=1 -> consecutive beats:
   - 8'h03 (head=1), 8'h11, 8'h22, 8'h44, 8'h77 (tail=1);
   - exactly 3 payload_req pulses;
   - done pulses one cycle after the tail beat.
2. start=1, len=0 -> header 8'h00, then tail 8'h00 on the next cycle; no payload_req; path IDLE->HEAD->TAIL->IDLE.
3. len=2, ready toggled 1,0,0,1,... -> data, head and tail held stable while ready=0; no payload_req during stalls; the beat sequence is identical to the unstalled run.
4. start held at 1 through the tail of a len=1 packet, second packet len=2 -> tail beat is followed immediately by the next header (TAIL->HEAD); the checksum restarts at 0 for the second packet.
5. Assert reset asynchronously mid-DATA (between clock edges) -> valid, head, tail and data go to 0 immediately; state=IDLE; no done; a later start produces a clean packet.
6. start pulsed while busy in DATA -> ignored: no extra header is emitted and the current packet completes unchanged.

Source files
------------

// File: rtl/pkt_frame_tx.sv
// pkt_frame_tx: transmit side of the head/data/tail packet framing link.
// Emits a header beat (length), len payload beats and an XOR-checksum tail.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, len        packet request and its payload length
//   payload           show-ahead payload word
//   payload_req       pops one payload word (combinational)
//   ready             receiver accepts the current beat
//   valid/head/tail   registered beat qualifiers
//   data              registered beat data
//   state, busy       FSM state and non-idle flag
//   done              one-cycle pulse after the tail beat is accepted
module pkt_frame_tx #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] payload,
    output logic              payload_req,
    input  logic              ready,
    output logic              valid,
    output logic              head,
    output logic              tail,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        state,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        DATA = 2'b10,
        TAIL = 2'b11
    } state_t;

    state_t            st;
    state_t            nst;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] csum;
    logic              acc;

    assign acc   = valid & ready;
    assign state = st;
    assign busy  = (st != IDLE);

    always_comb begin
        nst = st;
        unique case (st)
            IDLE: if (start) nst = HEAD;
            HEAD: if (acc) nst = (cnt == '0) ? TAIL : DATA;
            DATA: if (acc) nst = (cnt == '0) ? TAIL : DATA;
            TAIL: if (acc) nst = start ? HEAD : IDLE;
            default: nst = IDLE;
        endcase
    end

    // A word is popped only on the edge that loads it into data.
    assign payload_req = acc & (nst == DATA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= IDLE;
            valid <= 1'b0;
            head  <= 1'b0;
            tail  <= 1'b0;
            data  <= '0;
            done  <= 1'b0;
            csum  <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            st   <= nst;
            unique case (st)
                IDLE: begin
                    if (start) begin
                        cnt   <= len;
                        csum  <= '0;
                        valid <= 1'b1;
                        head  <= 1'b1;
                        tail  <= 1'b0;
                        data  <= DATA_W'(len);
                    end
                end
                HEAD, DATA: begin
                    if (acc) begin
                        head <= 1'b0;
                        if (cnt == '0) begin
                            // csum is still zero for a zero-length packet
                            tail <= 1'b1;
                            data <= csum;
                        end else begin
                            data <= payload;
                            csum <= csum ^ payload;
                            cnt  <= cnt - LEN_W'(1);
                        end
                    end
                end
                TAIL: begin
                    if (acc) begin
                        done <= 1'b1;
                        if (start) begin
                            cnt   <= len;
                            csum  <= '0;
                            valid <= 1'b1;
                            head  <= 1'b1;
                            tail  <= 1'b0;
                            data  <= DATA_W'(len);
                        end else begin
                            valid <= 1'b0;
                            head  <= 1'b0;
                            tail  <= 1'b0;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
